// File: rtl/image_proc_pkg.sv
// Shared definitions for the streaming morphology filter: mode encoding,
// FSM state encoding and the padding identity value.
package image_proc_pkg;

  localparam int unsigned MORPH_MAX_DW = 32;

  typedef enum logic {
    MORPH_DILATE = 1'b0,
    MORPH_ERODE  = 1'b1
  } morph_mode_e;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } morph_state_e;

  // Value that never wins the reduction: 0 for max, all-ones for min.
  function automatic logic [MORPH_MAX_DW-1:0] morph_identity(input morph_mode_e m);
    return (m == MORPH_ERODE) ? '1 : '0;
  endfunction

endpackage

// File: rtl/image_morph_stream_if.sv
// Pixel stream bundle: input stream (s_*) and output stream (m_*).
interface image_morph_stream_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/morph_line_buffer.sv
// One-line delay: dout is the sample written DEPTH enables ago.
module morph_line_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         ptr;

  // Oldest entry sits at the write pointer; read before overwrite.
  assign dout = mem[ptr];

  // Storage is never cleared; stale contents are masked downstream.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end

  // Circular pointer advances only with the window.
  always_ff @(posedge clk) begin
    if (!rst)                            ptr <= '0;
    else if (en && ptr == AW'(DEPTH-1))  ptr <= '0;
    else if (en)                         ptr <= ptr + AW'(1);
  end
endmodule

// File: rtl/image_morph_stream.sv
// Streaming KSIZE x KSIZE grey-level dilation/erosion over raster frames.
// The window is fed by a chain of line buffers; the reduction operates on
// the post-shift window so the result lands in the output register on the
// same edge that accepts the input pixel.
module image_morph_stream
  import image_proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned KSIZE      = 3
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 mode,
  image_morph_stream_if.slave bus
);
  localparam int unsigned H  = (KSIZE - 1) / 2;
  localparam int unsigned D  = H * IMG_W + H;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned AW = $clog2(D + 1);

  if (KSIZE < 3 || KSIZE > 7 || (KSIZE % 2) == 0) begin : g_bad_ksize
    $error("image_morph_stream: KSIZE must be odd and within 3..7");
  end
  if (IMG_W < KSIZE || IMG_H < KSIZE) begin : g_bad_frame
    $error("image_morph_stream: frame smaller than the kernel window");
  end
  if (DATA_WIDTH > MORPH_MAX_DW || DATA_WIDTH < 1) begin : g_bad_width
    $error("image_morph_stream: DATA_WIDTH out of range");
  end

  morph_state_e          state, state_next;
  morph_mode_e           frame_mode;
  logic [AW-1:0]         adv_cnt;
  logic [CW-1:0]         icol, ocol;
  logic [RW-1:0]         irow, orow;
  logic                  adv_ok, advance, accept, produce, s_ready_c;
  logic                  in_last, out_last;
  logic [DATA_WIDTH-1:0] shift_in;
  logic [KSIZE-1:0][DATA_WIDTH-1:0] tap;
  logic [DATA_WIDTH-1:0] win [KSIZE][KSIZE-1];
  logic [DATA_WIDTH-1:0] nw  [KSIZE][KSIZE];
  logic [KSIZE-1:0]      row_ok, col_ok;
  logic [DATA_WIDTH-1:0] reduced;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_valid_r, m_last_r;

  assign in_last  = (irow == RW'(IMG_H-1)) && (icol == CW'(IMG_W-1));
  assign out_last = (orow == RW'(IMG_H-1)) && (ocol == CW'(IMG_W-1));
  assign accept   = advance && (state != FLUSH);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= FILL;
    else      state <= state_next;
  end

  // Next state, handshake and window-advance control.
  always_comb begin
    adv_ok     = !bus.m_valid || bus.m_ready;
    state_next = state;
    s_ready_c  = 1'b0;
    advance    = 1'b0;
    produce    = 1'b0;
    shift_in   = bus.s_data;
    unique case (state)
      FILL: begin
        s_ready_c = 1'b1;
        advance   = bus.s_valid;
        if (advance && adv_cnt == AW'(D-1)) state_next = RUN;
      end
      RUN: begin
        s_ready_c = adv_ok;
        advance   = bus.s_valid && adv_ok;
        produce   = advance;
        if (advance && in_last) state_next = FLUSH;
      end
      FLUSH: begin
        advance  = adv_ok;
        produce  = advance;
        shift_in = '0;
        if (advance && adv_cnt == AW'(D-1)) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
    if (!rst) begin
      s_ready_c = 1'b0;
      advance   = 1'b0;
      produce   = 1'b0;
    end
  end

  assign bus.s_ready = s_ready_c;

  // Fill/flush progress counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (!rst)                                adv_cnt <= '0;
    else if (state_next != state)            adv_cnt <= '0;
    else if (advance && state != RUN)        adv_cnt <= adv_cnt + AW'(1);
  end

  // Input raster position, stepped on accepted pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      icol <= '0;
      irow <= '0;
    end else if (accept) begin
      if (icol == CW'(IMG_W-1)) begin
        icol <= '0;
        irow <= (irow == RW'(IMG_H-1)) ? '0 : irow + RW'(1);
      end else begin
        icol <= icol + CW'(1);
      end
    end
  end

  // Output raster position, stepped on produced pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ocol <= '0;
      orow <= '0;
    end else if (produce) begin
      if (ocol == CW'(IMG_W-1)) begin
        ocol <= '0;
        orow <= (orow == RW'(IMG_H-1)) ? '0 : orow + RW'(1);
      end else begin
        ocol <= ocol + CW'(1);
      end
    end
  end

  // Operation latched with the first pixel of each frame.
  always_ff @(posedge clk) begin
    if (!rst)                                  frame_mode <= MORPH_DILATE;
    else if (accept && irow == '0 && icol == '0) frame_mode <= morph_mode_e'(mode);
  end

  assign tap[0] = shift_in;

  for (genvar g = 0; g < KSIZE - 1; g++) begin : g_lb
    morph_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_W)
    ) u_lb (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .din  (tap[g]),
      .dout (tap[g+1])
    );
  end

  // Post-shift window: column 0 is the incoming tap column.
  // nw[i][j] holds the pixel i lines and j columns before the newest one.
  always_comb begin
    for (int unsigned i = 0; i < KSIZE; i++) begin
      nw[i][0] = tap[i];
      for (int unsigned j = 1; j < KSIZE; j++) nw[i][j] = win[i][j-1];
    end
  end

  // Window register shift on every advance.
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int unsigned i = 0; i < KSIZE; i++)
        for (int unsigned j = 0; j < KSIZE - 1; j++)
          win[i][j] <= nw[i][j];
    end
  end

  // Boundary mask: tap (i,j) maps to image position (orow+H-i, ocol+H-j).
  always_comb begin
    row_ok = '0;
    col_ok = '0;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      row_ok[i] = (int'(orow) + int'(H) - int'(i) >= 0) &&
                  (int'(orow) + int'(H) - int'(i) <  int'(IMG_H));
      col_ok[i] = (int'(ocol) + int'(H) - int'(i) >= 0) &&
                  (int'(ocol) + int'(H) - int'(i) <  int'(IMG_W));
    end
  end

  // Masked max/min fold; masked taps fall back to the identity value.
  always_comb begin
    reduced = DATA_WIDTH'(morph_identity(frame_mode));
    for (int unsigned i = 0; i < KSIZE; i++) begin
      for (int unsigned j = 0; j < KSIZE; j++) begin
        if (row_ok[i] && col_ok[j]) begin
          if (frame_mode == MORPH_ERODE) begin
            if (nw[i][j] < reduced) reduced = nw[i][j];
          end else begin
            if (nw[i][j] > reduced) reduced = nw[i][j];
          end
        end
      end
    end
  end

  // Output register: loads on produce, holds under backpressure.
  always_ff @(posedge clk) begin
    if (!rst) begin
      m_data_r  <= '0;
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (produce) begin
      m_data_r  <= reduced;
      m_valid_r <= 1'b1;
      m_last_r  <= out_last;
    end else if (bus.m_ready) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

  assign bus.m_data  = m_data_r;
  assign bus.m_valid = m_valid_r;
  assign bus.m_last  = m_last_r;

endmodule

// File: tb/tb_image_morph_stream.sv
// Scoreboard bench for image_morph_stream: an 8x6 frame with a 3x3 kernel
// and a second instance with a 5x5 kernel. Expected frames come from a
// direct neighbourhood max/min over the stored input image.
module tb_image_morph_stream;
  localparam int W    = 8;
  localparam int HH   = 6;
  localparam int NPIX = W * HH;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk, rst, mode3, mode5;
  logic [7:0] img [NPIX];
  exp_t q3[$];
  exp_t q5[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int rmode = 0;
  bit gaps  = 0;

  image_morph_stream_if #(.DATA_WIDTH(8)) if3 ();
  image_morph_stream_if #(.DATA_WIDTH(8)) if5 ();

  image_morph_stream #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(HH), .KSIZE(3)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .bus(if3)
  );
  image_morph_stream #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(HH), .KSIZE(5)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .bus(if5)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain neighbourhood reduction with identity outside the image.
  function automatic logic [7:0] ref_px(input int r, input int c, input int k, input logic md);
    int h;
    logic [7:0] v;
    h = (k - 1) / 2;
    v = md ? 8'hFF : 8'h00;
    for (int rr = r - h; rr <= r + h; rr++)
      for (int cc = c - h; cc <= c + h; cc++)
        if (rr >= 0 && rr < HH && cc >= 0 && cc < W) begin
          if (md) begin
            if (img[rr*W+cc] < v) v = img[rr*W+cc];
          end else begin
            if (img[rr*W+cc] > v) v = img[rr*W+cc];
          end
        end
    return v;
  endfunction

  // Downstream ready pattern: 0 always high, 1 high one cycle in three, 2 random.
  initial begin
    int cyc;
    cyc = 0;
    if3.m_ready = 1'b1;
    if5.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc = (cyc + 1) % 3;
      case (rmode)
        1:       begin if3.m_ready = (cyc == 2); if5.m_ready = (cyc == 2); end
        2:       begin if3.m_ready = 1'($urandom_range(0, 1)); if5.m_ready = 1'($urandom_range(0, 1)); end
        default: begin if3.m_ready = 1'b1; if5.m_ready = 1'b1; end
      endcase
    end
  end

  task automatic push_pix(input bit sel, input logic [7:0] px, input logic md);
    logic acc;
    int unsigned guard;
    acc = 1'b0;
    guard = 0;
    if (sel) begin if5.s_valid = 1'b1; if5.s_data = px; mode5 = md; end
    else     begin if3.s_valid = 1'b1; if3.s_data = px; mode3 = md; end
    while (!acc && guard < 300) begin
      @(negedge clk);
      acc = sel ? if5.s_ready : if3.s_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (sel) if5.s_valid = 1'b0; else if3.s_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: s_ready low for %0d cycles, expected 1", guard);
    end
  endtask

  // kind: 0 zeros+200@(2,3), 1 255s+10@(2,3), 2 random, 3 ramp r*8+c
  task automatic run_frame(input bit sel, input int kind, input logic md,
                           input int toggle_at, input int npix);
    int k;
    exp_t e;
    k = sel ? 5 : 3;
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       img[i] = (i == 2*W+3) ? 8'd200 : 8'd0;
        1:       img[i] = (i == 2*W+3) ? 8'd10  : 8'd255;
        3:       img[i] = 8'(i);
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < NPIX; i++) begin
      e.data = ref_px(i / W, i % W, k, md);
      e.last = (i == NPIX - 1);
      if (sel) q5.push_back(e); else q3.push_back(e);
    end
    for (int p = 0; p < npix; p++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      push_pix(sel, img[p], (toggle_at >= 0 && p >= toggle_at) ? ~md : md);
    end
  endtask

  task automatic wait_drain();
    int unsigned n;
    n = 0;
    while ((q3.size() != 0 || q5.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_q3", q3.size(), 0);
    check("drain_q5", q5.size(), 0);
  endtask

  task automatic mon_step(input bit sel);
    logic v, r, l;
    logic [7:0] d;
    exp_t e;
    int unsigned qs;
    if (sel) begin v = if5.m_valid; r = if5.m_ready; d = if5.m_data; l = if5.m_last; qs = q5.size(); end
    else     begin v = if3.m_valid; r = if3.m_ready; d = if3.m_data; l = if3.m_last; qs = q3.size(); end
    if (!rst || !v) return;
    if (qs == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_out k%0d: got data %0d with empty scoreboard, expected none", sel ? 5 : 3, d);
      return;
    end
    if (r) begin
      e = sel ? q5.pop_front() : q3.pop_front();
      check(sel ? "k5_data" : "k3_data", d, e.data);
      check(sel ? "k5_last" : "k3_last", l, e.last);
    end else begin
      e = sel ? q5[0] : q3[0];
      check(sel ? "k5_stall_data" : "k3_stall_data", d, e.data);
      check(sel ? "k5_stall_last" : "k3_stall_last", l, e.last);
    end
  endtask

  // Monitor: compares every presented output against the scoreboard head.
  always @(negedge clk) begin
    mon_step(1'b0);
    mon_step(1'b1);
  end

  initial begin
    rst = 1'b0;
    mode3 = 1'b0;
    mode5 = 1'b0;
    if3.s_valid = 1'b0; if3.s_data = '0;
    if5.s_valid = 1'b0; if5.s_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", if3.m_valid, 0);
    check("rst_m_last", if3.m_last, 0);
    check("rst_m_data", if3.m_data, 0);
    check("rst_s_ready", if3.s_ready, 0);
    check("rst_k5_m_valid", if5.m_valid, 0);
    rst = 1'b1;
    #1;
    check("rel_s_ready", if3.s_ready, 1);
    check("rel_k5_s_ready", if5.s_ready, 1);

    rmode = 0;
    run_frame(1'b0, 0, 1'b0, -1, NPIX);
    run_frame(1'b0, 1, 1'b1, -1, NPIX);
    rmode = 1;
    run_frame(1'b0, 0, 1'b0, -1, NPIX);
    rmode = 0;
    run_frame(1'b0, 2, 1'b0, 20, NPIX);
    run_frame(1'b0, 2, 1'b1, -1, NPIX);
    rmode = 2;
    gaps = 1;
    for (int f = 0; f < 3; f++)
      run_frame(1'b0, 2, 1'($urandom_range(0, 1)), int'($urandom_range(1, NPIX-1)), NPIX);
    wait_drain();
    gaps = 0;
    rmode = 0;

    run_frame(1'b0, 2, 1'b0, -1, 20);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_m_valid", if3.m_valid, 0);
    check("midrst_s_ready", if3.s_ready, 0);
    q3.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rel_s_ready", if3.s_ready, 1);
    run_frame(1'b0, 2, 1'b1, -1, NPIX);
    wait_drain();

    run_frame(1'b1, 3, 1'b0, -1, NPIX);
    rmode = 2;
    gaps = 1;
    run_frame(1'b1, 2, 1'b1, -1, NPIX);
    run_frame(1'b1, 2, 1'b0, 7, NPIX);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/image_morph_stream.md
IMAGE_MORPH_STREAM -- requirements
Module: image_morph_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 640, pixels per line.
REQ-003 Parameter IMG_H, default 480, lines per frame.
REQ-004 Parameter KSIZE, default 3, square kernel side; odd, 3..7; H = (KSIZE-1)/2.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 mode  in  1  0 = dilation (max), 1 = erosion (min).
REQ-008 s_valid  in  1  input pixel valid.
REQ-009 s_data  in  DATA_WIDTH  input pixel, raster order.
REQ-010 s_ready  out  1  block accepts s_data when s_valid && s_ready.
REQ-011 m_valid  out  1  output pixel valid.
REQ-012 m_data  out  DATA_WIDTH  filtered pixel.
REQ-013 m_last  out  1  high with the final output pixel of a frame.
REQ-014 m_ready  in  1  downstream accepts when m_valid && m_ready.

Function
REQ-015 Output (r,c) = max (dilation) or min (erosion) over the KSIZE x KSIZE neighbourhood centred on input (r,c); out-of-image taps contribute the identity value (0 for dilation, all-ones for erosion).
REQ-016 Each frame is exactly IMG_W*IMG_H inputs and produces exactly IMG_W*IMG_H outputs in raster order; there are no frame markers on input.
REQ-017 mode is sampled on acceptance of the first pixel of a frame and held for that frame; mid-frame changes are ignored.
REQ-018 The FSM has three states: FILL, RUN and FLUSH; the reset state is FILL.
REQ-019 FILL: s_ready=1, m_valid=0; after D = H*IMG_W + H accepted pixels, move to RUN.
REQ-020 RUN: each accepted input produces one output pixel, registered, valid on the next cycle; after the last input of the frame, move to FLUSH.
REQ-021 FLUSH: s_ready=0; the window advances one position per cycle with identity-padded taps when the output register is free; after D advances, move to FILL.
REQ-022 Backpressure: the output register holds m_data, m_valid and m_last while m_valid && !m_ready.
REQ-023 Throughput: the window may advance when !m_valid || m_ready; in RUN, s_ready equals that condition.
REQ-024 Throughput is one pixel per cycle with m_ready held high; there are no bubbles between back-to-back frames other than the FLUSH/FILL latency.
REQ-025 m_last is asserted only on output index IMG_W*IMG_H-1 of each frame.
REQ-026 Line/column counters wrap at IMG_W/IMG_H; the input and output position counters are independent.
REQ-027 If KSIZE*... window height exceeds the frame (IMG_H < KSIZE or IMG_W < KSIZE), elaboration is illegal and a build-time assertion fires.

Reset
REQ-028 While rst=0 at a clock edge: state=FILL, all counters=0, m_valid=0, m_last=0, m_data=0, s_ready=0; s_ready=1 from the first cycle after release.
REQ-029 Reset mid-frame discards the partial frame; line-buffer contents need not be cleared, because boundary masking guarantees no stale data reaches the output.

Structure
REQ-030 The mode encoding (MORPH_DILATE=0, MORPH_ERODE=1) and the identity-value function reside in the shared package image_proc_pkg.
REQ-031 KSIZE-1 line buffers of IMG_W depth are built from one sub-module, morph_line_buffer (parametrised DATA_WIDTH, DEPTH), each advancing only on the window-advance enable.
REQ-032 The KSIZE x KSIZE window registers, boundary mask and reduction tree reside in image_morph_stream; the reduction is combinational into the single output register.

Verification (IMG_W=8, IMG_H=6, KSIZE=3 unless stated)
REQ-033 Dilation, all-0 frame with 200 at (2,3), m_ready=1 -> 200 at rows 1..3, cols 2..4 (9 pixels), 0 elsewhere; 48 outputs; m_last only on output 47.
REQ-034 Erosion, all-255 frame with 10 at (2,3) -> 10 at rows 1..3, cols 2..4, 255 elsewhere including borders (identity padding verified).
REQ-035 Frame as REQ-033, m_ready high 1 cycle in 3 -> output sequence bit-identical to REQ-033, no loss or duplication, m_data stable while stalled.
REQ-036 Two back-to-back frames, mode 0 then 1, mode toggled at input pixel 20 of frame 1 -> frame 1 pure dilation, frame 2 pure erosion.
REQ-037 rst=0 for 1 cycle after 20 input pixels -> next cycle m_valid=0; s_ready=1 one cycle later; a following full frame matches the golden model exactly.
REQ-038 KSIZE=5, ramp input p(r,c)=r*8+c, dilation -> out(r,c)=p(min(r+2,5),min(c+2,7)); e.g. out(0,0)=18, out(5,7)=47.
